// File: rtl/spraid_spi_target.sv
// SPI mode-0 target with a Wishbone register port and RX/TX byte FIFOs.
// Optional interrupt output and IRQ_MASK register: define SPRAID_TGT_IRQ_EN.
module spraid_spi_target #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic        spi_clk_i,
    input  logic        spi_cs_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe
`ifdef SPRAID_TGT_IRQ_EN
   ,output logic        irq_o
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t r_state, w_state_nx;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic r_sclk_d, r_cs_d;
    logic w_sclk, w_cs, w_mosi, w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    logic        r_ack, r_en, r_miso, r_oe, r_reload, r_fill;
    logic [31:0] r_dat;
    logic [7:0]  r_tx_sr, r_rx_sr;
    logic [2:0]  r_bitcnt;
    logic        r_rx_ovf, r_tx_unf, r_abort, r_tx_ovf;

    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;

    logic          w_req, w_wr, w_rd, w_ctrl_wr, w_rx_flush, w_tx_flush;
    logic [1:0]    w_adr;
    logic [3:0]    w_w1c;
    logic          w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic [PW-1:0] w_rx_count;
    logic [5:0]    w_rx_cnt_ext;
    logic [3:0]    w_rx_cnt4;
    logic          w_rx_pop, w_rx_push_req, w_rx_push, w_tx_push_req, w_tx_push, w_tx_pop;
    logic [7:0]    w_rx_byte, w_rx_head, w_tx_head, w_load_val;
    logic          w_load, w_shift, w_rise, w_end;
    logic [31:0]   w_status, w_rdata, w_mask_rd;

    // Pin synchronizers plus one history flop for edge detection
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;

    // Wishbone decode; all side effects happen on the accept edge that raises ack
    assign w_req         = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_adr         = wb_adr_i[3:2];
    assign w_wr          = w_req & wb_we_i;
    assign w_rd          = w_req & ~wb_we_i;
    assign w_rx_pop      = w_rd & (w_adr == 2'd0) & ~w_rx_empty;
    assign w_tx_push_req = w_wr & (w_adr == 2'd0);
    assign w_tx_push     = w_tx_push_req & ~w_tx_full;
    assign w_ctrl_wr     = w_wr & (w_adr == 2'd2);
    assign w_rx_flush    = w_ctrl_wr & wb_dat_i[1];
    assign w_tx_flush    = w_ctrl_wr & wb_dat_i[2];
    assign w_w1c         = (w_wr && w_adr == 2'd1) ? wb_dat_i[7:4] : 4'h0;

    assign w_rx_empty   = (r_rx_wp == r_rx_rp);
    assign w_rx_full    = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
    assign w_tx_empty   = (r_tx_wp == r_tx_rp);
    assign w_tx_full    = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
    assign w_rx_count   = r_rx_wp - r_rx_rp;
    assign w_rx_cnt_ext = 6'(w_rx_count);
    assign w_rx_cnt4    = (w_rx_cnt_ext > 6'd15) ? 4'hF : w_rx_cnt_ext[3:0];
    assign w_rx_head    = r_rx_mem[r_rx_rp[AW-1:0]];
    assign w_tx_head    = r_tx_mem[r_tx_rp[AW-1:0]];

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // FSM next state
    always_comb begin
        w_state_nx = r_state;
        if (!r_en) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_cs_fall) w_state_nx = S_LOAD;
                S_LOAD:  w_state_nx = S_SHIFT;
                S_SHIFT: if (w_cs_rise) w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // FSM datapath strobes
    always_comb begin
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_rise  = 1'b0;
        w_end   = 1'b0;
        if (r_en) begin
            case (r_state)
                S_LOAD: w_load = 1'b1;
                S_SHIFT: begin
                    if (w_cs_rise)        w_end = 1'b1;
                    else if (w_sclk_rise) w_rise = 1'b1;
                    else if (w_sclk_fall) begin
                        w_load  = r_reload;
                        w_shift = ~r_reload;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_load_val    = w_tx_empty ? FILL_BYTE : w_tx_head;
    assign w_tx_pop      = w_load & ~w_tx_empty;
    assign w_rx_byte     = {r_rx_sr[6:0], w_mosi};
    assign w_rx_push_req = w_rise & (r_bitcnt == 3'd7);
    assign w_rx_push     = w_rx_push_req & ~w_rx_full;

    // Shift registers; underflow is flagged when a fill byte is actually clocked,
    // so the reload on the trailing fall of a frame never raises TX_UNF by itself
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tx_sr  <= FILL_BYTE;
            r_rx_sr  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_reload <= 1'b0;
            r_fill   <= 1'b0;
            r_miso   <= FILL_BYTE[7];
        end else begin
            if (w_load) begin
                r_tx_sr  <= w_load_val;
                r_miso   <= w_load_val[7];
                r_fill   <= w_tx_empty;
                r_reload <= 1'b0;
            end
            if (w_shift) begin
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                r_miso  <= r_tx_sr[6];
            end
            if (w_rise) begin
                r_rx_sr  <= w_rx_byte;
                r_bitcnt <= 3'(r_bitcnt + 3'd1);
                r_fill   <= 1'b0;
                if (r_bitcnt == 3'd7) r_reload <= 1'b1;
            end
            if (w_end || r_state == S_IDLE || r_state == S_LOAD) begin
                r_bitcnt <= 3'd0;
                if (r_state != S_LOAD) begin
                    r_reload <= 1'b0;
                    r_fill   <= 1'b0;
                end
            end
        end
    end

    // FIFO pointers: flush beats a same-cycle push
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_wp <= '0; r_rx_rp <= '0;
            r_tx_wp <= '0; r_tx_rp <= '0;
        end else begin
            if (w_rx_flush) begin
                r_rx_wp <= '0; r_rx_rp <= '0;
            end else begin
                if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
            end
            if (w_tx_flush) begin
                r_tx_wp <= '0; r_tx_rp <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= w_rx_byte;
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= wb_dat_i[7:0];
    end

    // Sticky flags, CTRL, MISO enable and Wishbone response; a set beats a W1C
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_ovf <= 1'b0; r_tx_unf <= 1'b0; r_abort <= 1'b0; r_tx_ovf <= 1'b0;
            r_en     <= 1'b0;
            r_oe     <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= 32'h0;
        end else begin
            r_rx_ovf <= (w_rx_push_req & w_rx_full) | (r_rx_ovf & ~w_w1c[0]);
            r_tx_unf <= (w_rise & r_fill) | (r_tx_unf & ~w_w1c[1]);
            r_abort  <= (w_end & (r_bitcnt != 3'd0)) | (r_abort & ~w_w1c[2]);
            r_tx_ovf <= (w_tx_push_req & w_tx_full) | (r_tx_ovf & ~w_w1c[3]);
            if (w_ctrl_wr) r_en <= wb_dat_i[0];
            r_oe  <= r_en & ~w_cs;
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : 32'h0;
        end
    end

    assign w_status = {16'h0, w_rx_cnt4, 3'b000, ~w_cs,
                       r_tx_ovf, r_abort, r_tx_unf, r_rx_ovf,
                       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

`ifdef SPRAID_TGT_IRQ_EN
    logic [7:0] r_mask;
    logic       r_irq;
    logic [7:0] w_irq_src;

    assign w_irq_src = {w_status[7:3], w_tx_empty, w_status[1], ~w_rx_empty};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_mask <= 8'h00;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && w_adr == 2'd3) r_mask <= wb_dat_i[7:0];
            r_irq <= |(w_irq_src & r_mask);
        end
    end

    assign w_mask_rd = {24'h0, r_mask};
    assign irq_o     = r_irq;
`else
    assign w_mask_rd = 32'h0;
`endif

    always_comb begin
        w_rdata = 32'h0;
        case (w_adr)
            2'd0: w_rdata = {24'h0, w_rx_empty ? 8'h00 : w_rx_head};
            2'd1: w_rdata = w_status;
            2'd2: w_rdata = {31'h0, r_en};
            2'd3: w_rdata = w_mask_rd;
            default: w_rdata = 32'h0;
        endcase
    end

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat;
    assign spi_miso_o  = r_miso;
    assign spi_miso_oe = r_oe;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};
endmodule

// File: tb/tb_spraid_spi_target.sv
// Directed bench for spraid_spi_target: register table plus SPI frame sequences.
module tb_spraid_spi_target;
    logic        clk = 1'b0, rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe;
`ifdef SPRAID_TGT_IRQ_EN
    logic        irq;
    localparam logic [31:0] MASK_RB = 32'h0000_00A5;
`else
    localparam logic [31:0] MASK_RB = 32'h0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    spraid_spi_target dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_ack_o(ack), .wb_dat_o(rdat),
        .spi_clk_i(sclk), .spi_cs_i(cs), .spi_mosi_i(mosi),
        .spi_miso_o(miso), .spi_miso_oe(miso_oe)
`ifdef SPRAID_TGT_IRQ_EN
       ,.irq_o(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        bit got = 0;
        q = 32'h0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1;
                q = rdat;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL wb_timeout: no ack for adr %h, expected ack within 4 cycles", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic rd_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(1'b0, a, 32'h0, q);
        check(nm, q, exp);
    endtask

    task automatic spi_half();
        repeat (8) @(negedge clk);
    endtask

    // Mode 0: present MOSI while SCLK is low, sample MISO just before the rise
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            spi_half();
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            spi_half();
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        spi_half();
    endtask

    task automatic cs_high();
        spi_half();
        cs = 1'b1;
        spi_half();
        spi_half();
    endtask

    initial begin
        logic [7:0]  mbyte;
        logic [31:0] q;

        vecs[0]  = '{1'b0, 32'hF000_0004, 32'h0,  32'h0000_0005};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,  32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0,  32'h0};
        vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,  32'h0};
        vecs[4]  = '{1'b1, 32'h0000_000C, 32'hA5, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_000C, 32'h0,  MASK_RB};
        vecs[6]  = '{1'b1, 32'h0000_000C, 32'h0,  32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0008, 32'h7,  32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0008, 32'h0,  32'h1};
        vecs[9]  = '{1'b1, 32'h0000_0008, 32'h0,  32'h0};
        for (int i = 0; i < 9; i++)
            vecs[10+i] = '{1'b1, 32'h0000_0000, 32'h10 + 32'(i), 32'h0};
        vecs[19] = '{1'b0, 32'h0000_0004, 32'h0,  32'h0000_0089};
        vecs[20] = '{1'b1, 32'h0000_0008, 32'h4,  32'h0};
        vecs[21] = '{1'b0, 32'h0000_0004, 32'h0,  32'h0000_0085};
        vecs[22] = '{1'b1, 32'h0000_0004, 32'h80, 32'h0};
        vecs[23] = '{1'b0, 32'h0000_0004, 32'h0,  32'h0000_0005};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_dat", rdat, 32'h0);
        check("reset_miso", 32'(miso), 32'h1);
        check("reset_oe", 32'(miso_oe), 32'h0);
`ifdef SPRAID_TGT_IRQ_EN
        check("reset_irq", 32'(irq), 32'h0);
`endif

        for (int i = 0; i < 24; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, q);
            check($sformatf("vec%0d", i), q, vecs[i].exp);
        end

        // Held strobe: acked every other cycle, data zero between acks
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("held_ack%0d", k), 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("held_dat%0d", k), rdat, (k % 2 == 0) ? 32'h5 : 32'h0);
        end
        stb = 1'b0; cyc = 1'b0;

        // 1: single byte with empty TX
        wr(32'h8, 32'h1);
        cs_low(); spi_bits(8'hA5, 8, mbyte); cs_high();
        check("t1_miso", 32'(mbyte), 32'hFF);
        rd_check("t1_status_pre", 32'h4, 32'h0000_1024);
        rd_check("t1_data", 32'h0, 32'hA5);
        rd_check("t1_status", 32'h4, 32'h0000_0025);
        wr(32'h4, 32'hF0);
        rd_check("t1_w1c", 32'h4, 32'h0000_0005);

        // 2: two queued TX bytes in a two-byte frame
        wr(32'h0, 32'h3C);
        wr(32'h0, 32'h81);
        cs_low();
        spi_bits(8'h11, 8, mbyte); check("t2_miso0", 32'(mbyte), 32'h3C);
        spi_bits(8'h22, 8, mbyte); check("t2_miso1", 32'(mbyte), 32'h81);
        cs_high();
        rd_check("t2_data0", 32'h0, 32'h11);
        rd_check("t2_data1", 32'h0, 32'h22);
        rd_check("t2_status", 32'h4, 32'h0000_0005);

        // 3: RX overflow
        cs_low();
        for (int i = 0; i < 9; i++) spi_bits(8'h40 + 8'(i), 8, mbyte);
        cs_high();
        rd_check("t3_status", 32'h4, 32'h0000_8036);
        for (int i = 0; i < 8; i++) rd_check($sformatf("t3_data%0d", i), 32'h0, 32'h40 + 32'(i));
        wr(32'h4, 32'h10);
        rd_check("t3_w1c", 32'h4, 32'h0000_0025);
        wr(32'h4, 32'hF0);

        // 4: aborted partial byte, then a clean byte
        cs_low(); spi_bits(8'hF0, 5, mbyte); cs_high();
        rd_check("t4_abort", 32'h4, 32'h0000_0065);
        wr(32'h4, 32'hF0);
        cs_low(); spi_bits(8'h5A, 8, mbyte); cs_high();
        rd_check("t4_data", 32'h0, 32'h5A);
        rd_check("t4_empty", 32'h0, 32'h0);

        // 5: reset in the middle of a byte
        wr(32'h4, 32'hF0);
        cs_low(); spi_bits(8'h77, 8, mbyte); cs_high();
        wr(32'h0, 32'h99);
        cs_low(); spi_bits(8'hC3, 4, mbyte);
        check("t5_oe_active", 32'(miso_oe), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ack", 32'(ack), 32'h0);
        check("t5_dat", rdat, 32'h0);
        check("t5_miso", 32'(miso), 32'h1);
        check("t5_oe", 32'(miso_oe), 32'h0);
        cs = 1'b1;
        spi_half();
        rd_check("t5_status", 32'h4, 32'h0000_0005);
        rd_check("t5_ctrl", 32'h8, 32'h0);
        rd_check("t5_data", 32'h0, 32'h0);

`ifdef SPRAID_TGT_IRQ_EN
        // 6: RX-not-empty interrupt
        wr(32'hC, 32'h1);
        wr(32'h8, 32'h1);
        repeat (2) @(negedge clk);
        check("t6_irq_idle", 32'(irq), 32'h0);
        cs_low(); spi_bits(8'h33, 8, mbyte); cs_high();
        check("t6_irq_set", 32'(irq), 32'h1);
        rd_check("t6_data", 32'h0, 32'h33);
        repeat (2) @(negedge clk);
        check("t6_irq_clr", 32'(irq), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
